commit_wb_arbiter: RTL

//  Shares the single register-file writeback port among the execute-unit commit

---
 rtl/commit_wb_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/commit_wb_arbiter.sv
// Round-robin arbiter sharing the register-file writeback port among commit streams,
// with a registered valid/ready output stage. Optional stall counters: COMMIT_ARB_PERF_EN.
module commit_wb_arbiter #(
    parameter int NUM_REQS      = 5,
    parameter int DATAW         = 64,
    parameter int PERF_CTR_BITS = 44
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS*DATAW-1:0]     req_data,
    output logic [NUM_REQS-1:0]           req_ready,
    output logic                          wb_valid,
    output logic [DATAW-1:0]              wb_data,
    output logic [$clog2(NUM_REQS)-1:0]   wb_sel,
`ifdef COMMIT_ARB_PERF_EN
    output logic [NUM_REQS*PERF_CTR_BITS-1:0] perf_stalls,
`endif
    input  logic                          wb_ready
);

    localparam int SELW = $clog2(NUM_REQS);
    localparam logic [SELW-1:0] RR_INIT = SELW'(NUM_REQS - 1);

    logic [SELW-1:0]     rr_ptr;
    logic [NUM_REQS-1:0] grant;
    logic [SELW-1:0]     grant_idx;
    logic [DATAW-1:0]    grant_data;
    logic                any_grant;
    logic                out_ready;
    logic                fire;
    int                  cand;

    // Stage p0: combinational round-robin pick starting just after rr_ptr
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        grant_data = '0;
        any_grant  = 1'b0;
        cand       = 0;
        for (int k = 1; k <= NUM_REQS; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_REQS;
            if (!any_grant && req_valid[cand]) begin
                any_grant     = 1'b1;
                grant[cand]   = 1'b1;
                grant_idx     = SELW'(cand);
                grant_data    = req_data[cand*DATAW +: DATAW];
            end
        end
    end

    assign out_ready = !wb_valid || wb_ready;
    assign req_ready = reset ? '0 : (grant & {NUM_REQS{out_ready}});
    assign fire      = any_grant && out_ready && !reset;

    // Stage p1: registered writeback output; pointer advances only on a fire
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_sel   <= '0;
            rr_ptr   <= RR_INIT;
        end else if (fire) begin
            wb_valid <= 1'b1;
            wb_data  <= grant_data;
            wb_sel   <= grant_idx;
            rr_ptr   <= grant_idx;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

`ifdef COMMIT_ARB_PERF_EN
    logic [PERF_CTR_BITS-1:0] stall_cnt [NUM_REQS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQS; i++) begin
            if (reset) begin
                stall_cnt[i] <= '0;
            end else if (req_valid[i] && !req_ready[i]) begin
                stall_cnt[i] <= stall_cnt[i] + PERF_CTR_BITS'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_perf
        assign perf_stalls[g*PERF_CTR_BITS +: PERF_CTR_BITS] = stall_cnt[g];
    end
`endif

endmodule
